t04_memory_responder: RTL and testbench
=======================================

# t04_memory_responder

Memory-side responder for the team-04 core datapath. It accepts the core's combined request (`final_address`, `mem_store`, `MemRead_O`, `MemWrite_O`) and runs the access on a single-port word memory port. It then returns the result with a one-cycle `i_ack` (instruction fetch) or `d_ack` (data access), together with registered `instruction` / `memload`. It sits between the datapath and the SRAM/bus wrapper and is the sole source of the core's acknowledge handshake.

## Interface
- `RESET_INSTR`, 32'h0000_0013, value of `instruction` after reset and on fetch timeout (NOP)
- `TIMEOUT_CYCLES`, 16'd255, maximum REQ-state cycles before abort (range 1..65535; used only with the macro)

- `clk` input 1 — system clock, all state on rising edge
- `rst` input 1 — reset, asynchronous, active-low
- `en` input 1 — core enable; 0 holds block in IDLE
- `final_address` input 32 — core request byte address
- `mem_store` input 32 — core store data
- `MemRead_O` input 1 — data read request
- `MemWrite_O` input 1 — data write request
- `i_ack` output 1 — fetch complete pulse
- `d_ack` output 1 — data access complete pulse
- `instruction` output 32 — last fetched word
- `memload` output 32 — last loaded data word
- `mem_req` output 1 — memory port request
- `mem_we` output 1 — memory port write enable
- `mem_addr` output 32 — word-aligned address, `{addr[31:2],2'b00}`
- `mem_wdata` output 32 — write data
- `mem_rdata` input 32 — read data, valid when `mem_ready`=1
- `mem_ready` input 1 — memory completes current access this cycle
- `bus_err` output 1 — sticky timeout flag

## Operation
- Kind decode when sampled:
  - `MemWrite_O`=1 → WRITE. Write wins if both strobes are set.
  - else `MemRead_O`=1 → READ.
  - else → FETCH.
- States:
  - IDLE: with `en`=1, capture address, store data and kind on the edge, then go to REQ. With `en`=0, stay in IDLE.
  - REQ: `mem_req`=1. `mem_we`=1 only for WRITE. `mem_addr`/`mem_wdata` come from the captured registers; core inputs are ignored. Stay until `mem_ready`=1 is sampled. On that edge, for FETCH load `instruction` ← `mem_rdata`; for READ load `memload` ← `mem_rdata`. Go to ACK.
  - ACK: exactly one of `i_ack` (FETCH) or `d_ack` (READ, WRITE) is 1 for one cycle. Go to IDLE.
- A WRITE never changes `memload`. A READ never changes `instruction`. Both hold their values between accesses.
- Address bits [1:0] are dropped. Only full-word access is supported.
- Reset values: state IDLE, `i_ack`/`d_ack`/`mem_req`/`mem_we`/`bus_err` = 0, `mem_addr`/`mem_wdata`/`memload` = 0, `instruction` = `RESET_INSTR`.
- Reset mid-transaction: the block returns to IDLE asynchronously, `mem_req` drops immediately, and no ack is issued.

## Timing
- Zero-wait memory (`mem_ready`=1 in the first REQ cycle):
  - sample edge N
  - `mem_req` high in cycle N+1
  - ack high in cycle N+2
  - the next sample is at edge N+3
- Each wait cycle (`mem_ready`=0 in REQ) adds one cycle of latency.
- `mem_ready` is ignored outside REQ.
- `instruction`/`memload` update on the same edge that enters ACK, so they are valid while the ack is high and afterwards.
- Acks never overlap and are never high for two consecutive cycles.
- `en` falling during REQ/ACK does not abort the transaction. It takes effect in IDLE.

## Configuration
- `T04_MEM_TIMEOUT_EN` defined:
  - A 16-bit counter clears on REQ entry and increments each REQ cycle with `mem_ready`=0.
  - When the count reaches `TIMEOUT_CYCLES` without `mem_ready`, the block drops `mem_req` and enters ACK with the normal ack.
  - Abort data: FETCH loads `instruction` ← `RESET_INSTR`, READ loads `memload` ← 0.
  - `bus_err` is set and stays set until reset.
  - `mem_ready`=1 on the same cycle the count hits the limit counts as success.
- Not defined: no counter; REQ waits indefinitely and `bus_err` is tied 0.

## Test plan
- Reset, then release with `en`=1, FETCH to 0x0000_0004, `mem_rdata`=0x0000_0093, zero wait → `mem_addr`=0x4 in cycle 1, `i_ack` pulse in cycle 2, `instruction`=0x0000_0093.
- READ from 0x0000_1003 with 3 wait cycles, `mem_rdata`=0xDEAD_BEEF → `mem_addr`=0x1000, `d_ack` 5 cycles after the sample, `memload`=0xDEAD_BEEF, `instruction` unchanged.
- `MemRead_O`=`MemWrite_O`=1, addr 0x20, data 0x1234_5678 → `mem_we`=1, `mem_wdata`=0x1234_5678, `d_ack` pulse, `memload` unchanged.
- Core changes `final_address` mid-REQ from 0x40 to 0x80 → `mem_addr` stays 0x40 until ACK.
- Assert `rst`=0 during REQ → `mem_req`=0 immediately, no ack, `instruction`=0x0000_0013.
- With macro, `TIMEOUT_CYCLES`=4, `mem_ready` held 0 on a READ → `mem_req` drops after 4 REQ cycles, `d_ack` pulse, `memload`=0, `bus_err`=1 held.

Source files
------------

// File: rtl/t04_memory_responder.sv
// Memory-side responder: runs core fetch/load/store on a word port, issues i_ack/d_ack.
// Optional REQ timeout abort with sticky bus_err: define T04_MEM_TIMEOUT_EN.
module t04_memory_responder #(
  parameter logic [31:0] RESET_INSTR    = 32'h0000_0013,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] final_address,
  input  logic [31:0] mem_store,
  input  logic        MemRead_O,
  input  logic        MemWrite_O,
  output logic        i_ack,
  output logic        d_ack,
  output logic [31:0] instruction,
  output logic [31:0] memload,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK
  } state_e;

  typedef enum logic [1:0] {
    K_FETCH,
    K_READ,
    K_WRITE
  } kind_e;

  state_e      state_q;
  kind_e       kind_q, kind_d;
  logic        i_ack_q, d_ack_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [31:0] instr_q, load_q;
  logic        abort;

  // Write has priority when both strobes are raised
  always_comb begin
    kind_d = K_FETCH;
    unique case (1'b1)
      MemWrite_O:              kind_d = K_WRITE;
      MemRead_O & ~MemWrite_O: kind_d = K_READ;
      default:                 kind_d = K_FETCH;
    endcase
  end

`ifdef T04_MEM_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        bus_err_q;

  assign cnt_d = cnt_q + 16'd1;
  assign abort = (state_q == S_REQ) && !mem_ready
                 && (cnt_d == TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (state_q != S_REQ)
        cnt_q <= '0;
      else if (!mem_ready)
        cnt_q <= cnt_d;
      if (abort)
        bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      kind_q      <= K_FETCH;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      instr_q     <= RESET_INSTR;
      load_q      <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (en) begin
            kind_q      <= kind_d;
            mem_addr_q  <= final_address & 32'hFFFF_FFFC;
            mem_wdata_q <= mem_store;
            mem_req_q   <= 1'b1;
            mem_we_q    <= (kind_d == K_WRITE);
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready || abort) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            i_ack_q   <= (kind_q == K_FETCH);
            d_ack_q   <= (kind_q != K_FETCH);
            state_q   <= S_ACK;
            // A ready in the limit cycle wins over the abort
            if (kind_q == K_FETCH)
              instr_q <= mem_ready ? mem_rdata : RESET_INSTR;
            if (kind_q == K_READ)
              load_q <= mem_ready ? mem_rdata : 32'h0;
          end
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign i_ack       = i_ack_q;
  assign d_ack       = d_ack_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign instruction = instr_q;
  assign memload     = load_q;

endmodule

// File: tb/tb_t04_memory_responder.sv
// Randomized bench for t04_memory_responder against a word-memory reference model.
// Timeout abort is exercised when T04_MEM_TIMEOUT_EN is defined.
module tb_t04_memory_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] final_address;
  logic [31:0] mem_store;
  logic        MemRead_O;
  logic        MemWrite_O;
  logic        i_ack;
  logic        d_ack;
  logic [31:0] instruction;
  logic [31:0] memload;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;

  t04_memory_responder #(
    .RESET_INSTR   (NOP),
    .TIMEOUT_CYCLES(16'd4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .final_address(final_address),
    .mem_store    (mem_store),
    .MemRead_O    (MemRead_O),
    .MemWrite_O   (MemWrite_O),
    .i_ack        (i_ack),
    .d_ack        (d_ack),
    .instruction  (instruction),
    .memload      (memload),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [logic [29:0]];
  logic [31:0] instr_m;
  logic [31:0] load_m;
  logic        berr_m;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2];
    if (!mem_m.exists(w))
      mem_m[w] = $urandom;
    return mem_m[w];
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_instr"}, instruction, instr_m);
    chk({tag, "_load"}, memload, load_m);
    chk({tag, "_berr"}, 32'(bus_err), 32'(berr_m));
  endtask

  // kind: 0 fetch, 1 read, 2 write, 3 read+write strobes
  task automatic txn(input int kind, input logic [31:0] addr,
                     input logic [31:0] data, input int waits,
                     input bit chaos);
    logic [31:0] rv;
    bit wr, rd;
    wr = (kind >= 2);
    rd = (kind == 1);
    @(negedge clk);
    en            = 1'b1;
    final_address = addr;
    mem_store     = data;
    MemRead_O     = (kind == 1) || (kind == 3);
    MemWrite_O    = wr;
    mem_ready     = 1'($urandom);
    mem_rdata     = $urandom;
    @(posedge clk);
    @(negedge clk);
    if (chaos) begin
      en            = 1'($urandom);
      final_address = $urandom;
      mem_store     = $urandom;
      MemRead_O     = 1'($urandom);
      MemWrite_O    = 1'($urandom);
    end
    rv = wr ? 32'h0 : rd_word(addr);
    for (int k = 0; k <= waits; k++) begin
      chk("req", 32'(mem_req), 32'd1);
      chk("we", 32'(mem_we), 32'(wr));
      chk("addr", mem_addr, addr & 32'hFFFF_FFFC);
      if (wr)
        chk("wdata", mem_wdata, data);
      chk("ack_in_req", 32'({i_ack, d_ack}), 32'd0);
      mem_ready = (k == waits);
      mem_rdata = (k == waits) ? rv : $urandom;
      @(negedge clk);
    end
    if (wr)
      mem_m[addr[31:2]] = data;
    else if (rd)
      load_m = rv;
    else
      instr_m = rv;
    chk("i_ack", 32'(i_ack), 32'(!wr && !rd));
    chk("d_ack", 32'(d_ack), 32'(wr || rd));
    chk("req_in_ack", 32'(mem_req), 32'd0);
    chk_state("ack");
    en        = 1'b0;
    mem_ready = 1'($urandom);
  endtask

  initial begin
    rst           = 1'b0;
    en            = 1'b0;
    final_address = '0;
    mem_store     = '0;
    MemRead_O     = 1'b0;
    MemWrite_O    = 1'b0;
    mem_rdata     = '0;
    mem_ready     = 1'b0;
    instr_m       = NOP;
    load_m        = '0;
    berr_m        = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk_state("rst");
    rst = 1'b1;

    mem_m[30'h1] = 32'h0000_0093;
    txn(0, 32'h0000_0004, 32'h0, 0, 1'b0);
    chk("fetch_instr", instruction, 32'h0000_0093);

    mem_m[30'h400] = 32'hDEAD_BEEF;
    txn(1, 32'h0000_1003, 32'h0, 3, 1'b0);
    chk("read_load", memload, 32'hDEAD_BEEF);
    chk("read_instr", instruction, 32'h0000_0093);

    txn(3, 32'h0000_0020, 32'h1234_5678, 1, 1'b0);
    chk("both_load", memload, 32'hDEAD_BEEF);

    txn(0, 32'h0000_0040, 32'h0, 2, 1'b1);

    // Idle with en low: nothing must start
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      final_address = $urandom;
      MemRead_O     = 1'($urandom);
      mem_ready     = 1'($urandom);
      chk("idle_req", 32'(mem_req), 32'd0);
      chk("idle_ack", 32'({i_ack, d_ack}), 32'd0);
    end

    // Reset in the middle of a request
    @(negedge clk);
    en            = 1'b1;
    final_address = 32'h0000_0010;
    MemRead_O     = 1'b0;
    MemWrite_O    = 1'b0;
    mem_ready     = 1'b0;
    @(negedge clk);
    chk("mid_req", 32'(mem_req), 32'd1);
    en  = 1'b0;
    rst = 1'b0;
    #1;
    instr_m = NOP;
    load_m  = '0;
    berr_m  = 1'b0;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_ack", 32'({i_ack, d_ack}), 32'd0);
    chk_state("mid_rst");
    @(negedge clk);
    rst       = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_ack", 32'({i_ack, d_ack}), 32'd0);
      chk("post_rst_req", 32'(mem_req), 32'd0);
    end

`ifdef T04_MEM_TIMEOUT_EN
    @(negedge clk);
    en            = 1'b1;
    final_address = 32'h0000_0300;
    MemRead_O     = 1'b1;
    MemWrite_O    = 1'b0;
    mem_ready     = 1'b0;
    mem_rdata     = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("to_req", 32'(mem_req), 32'd1);
      @(negedge clk);
    end
    load_m = '0;
    berr_m = 1'b1;
    chk("to_req_drop", 32'(mem_req), 32'd0);
    chk("to_d_ack", 32'(d_ack), 32'd1);
    chk_state("to");
    repeat (3) @(negedge clk);
    chk("to_berr_held", 32'(bus_err), 32'd1);
`endif

    for (int n = 0; n < 150; n++) begin
      txn($urandom_range(0, 3), 32'($urandom_range(0, 255)),
          $urandom, $urandom_range(0, 3), 1'($urandom));
    end

    @(negedge clk);
    chk_state("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
